mem_lsu: RTL

//  MEM-stage load/store unit; consumes the EX-stage result (we, address/rd, wdata) and completes the RISC-V access.

---
 rtl/mem_lsu_pkg.sv | 47 ++++
 rtl/mem_lsu_if.sv | 16 +
 rtl/mem_lsu_load_extend.sv | 26 ++
 rtl/mem_lsu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lsu_pkg
//  Brief   : Shared opcodes, access-size and state encodings for mem_lsu.
//  Revision: 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  // funct3[1:0] width codes
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // Number of bytes moved for a width code (1, 2 or 4)
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // LB/LH/LW/LBU/LHU
  function automatic logic f3_legal_load(input logic [2:0] f3);
    f3_legal_load = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // SB/SH/SW
  function automatic logic f3_legal_store(input logic [2:0] f3);
    f3_legal_store = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lsu_if
//  Brief   : 8-bit external memory port between the LSU and memory.
//  Revision: 1.0 - initial release
// ============================================================================
interface mem_lsu_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;

  modport master (output mem_a, output mem_dout, output mem_wr, input mem_din);
  modport slave  (input mem_a, input mem_dout, input mem_wr, output mem_din);
endinterface
`default_nettype wire

// File: rtl/mem_lsu_load_extend.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lsu_load_extend
//  Brief   : Sign/zero-extends the little-endian packed load bytes.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_lsu_load_extend
  import mem_lsu_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] word_o
);

  // Extend from the top byte actually loaded
  always_comb begin
    case (size_i)
      SZ_BYTE: word_o = {{24{sign_i & bytes_i[7]}},  bytes_i[7:0]};
      SZ_HALF: word_o = {{16{sign_i & bytes_i[15]}}, bytes_i[15:0]};
      default: word_o = bytes_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lsu
//  Brief   : MEM-stage load/store unit, serialises accesses over an 8-bit
//            memory port one byte per cycle and stalls upstream while busy.
//  Config  : MEM_ALIGN_CHECK_EN adds the misalign output and skips memory
//            cycles for misaligned half/word accesses.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic        we_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  mem_lsu_if.master   mem,
  output logic        we_wb,
  output logic [4:0]  waddr_wb,
  output logic [31:0] wdata_wb,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        stall_req
);

  localparam logic [3:0] c_rl    = 4'(READ_LAT);
  localparam logic [1:0] c_rl_lo = 2'(READ_LAT);
  localparam logic [1:0] c_rl_m1 = 2'(READ_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_q, drain_q;
  logic [31:0] addr_q, data_q;
  logic [4:0]  rd_q;
  logic        we_q, sign_q, is_load_q;
  size_e       size_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        we_wb_q;
  logic [4:0]  waddr_wb_q;
  logic [31:0] wdata_wb_q;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_q;
`endif

  logic        w_is_load, w_is_store, w_mem_op, w_misal;
  logic [2:0]  w_n;
  logic        w_last_issue, w_last_drain;
  logic [1:0]  w_next_byte;
  logic [3:0]  w_cap_sum;
  logic        w_cap_en;
  logic [1:0]  w_cap_idx;
  logic [31:0] w_packed, w_ext;

  // Decode the EX-stage op; illegal widths fall back to non-memory handling
  always_comb begin
    w_is_load  = (opcode_in == c_op_load);
    w_is_store = (opcode_in == c_op_store);
    w_mem_op   = (w_is_load && f3_legal_load(funct3_in)) ||
                 (w_is_store && f3_legal_store(funct3_in));
    w_misal    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    w_misal    = ((funct3_in[1:0] == SZ_HALF) && addr_in[0]) ||
                 ((funct3_in[1:0] == SZ_WORD) && (addr_in[1:0] != 2'b00));
`endif
  end

  // Byte sequencing and load capture: byte k returns READ_LAT active cycles after its issue
  always_comb begin
    w_n          = size_bytes(size_q);
    w_last_issue = ({1'b0, byte_q} == (w_n - 3'd1));
    w_last_drain = (drain_q == c_rl_m1);
    w_next_byte  = byte_q + 2'd1;
    case (state_q)
      S_ISSUE: w_cap_sum = {2'b00, byte_q};
      S_DRAIN: w_cap_sum = {1'b0, w_n} + {2'b00, drain_q};
      default: w_cap_sum = 4'd0;
    endcase
    w_cap_en  = is_load_q && ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                (w_cap_sum >= c_rl);
    w_cap_idx = w_cap_sum[1:0] - c_rl_lo;
    w_packed  = data_q;
    if (w_cap_en) w_packed[{w_cap_idx, 3'b000} +: 8] = mem.mem_din;
  end

  mem_lsu_load_extend u_ext (
    .bytes_i (w_packed),
    .size_i  (size_q),
    .sign_i  (sign_q),
    .word_o  (w_ext)
  );

  // State register, frozen while rdy is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state_q <= S_IDLE;
    else if (rdy) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_mem_op) state_d = w_misal ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last_issue) state_d = is_load_q ? S_DRAIN : S_DONE;
      S_DRAIN: if (w_last_drain) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Upstream hold: accepting cycle plus every busy cycle; released in DONE
  always_comb begin
    stall_req = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE:  stall_req = w_mem_op;
        S_ISSUE: stall_req = 1'b1;
        S_DRAIN: stall_req = 1'b1;
        default: stall_req = 1'b0;
      endcase
    end
  end

  // Datapath: operand latch, memory port drive, load assembly and write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q     <= 2'd0;
      drain_q    <= 2'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      is_load_q  <= 1'b0;
      size_q     <= SZ_BYTE;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      we_wb_q    <= 1'b0;
      waddr_wb_q <= 5'd0;
      wdata_wb_q <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (w_mem_op) begin
            addr_q    <= addr_in;
            data_q    <= w_is_load ? 32'd0 : wdata_in;
            rd_q      <= rd_in;
            we_q      <= we_in;
            size_q    <= size_e'(funct3_in[1:0]);
            sign_q    <= !funct3_in[2];
            is_load_q <= w_is_load;
            byte_q    <= 2'd0;
            drain_q   <= 2'd0;
            we_wb_q   <= 1'b0;
            if (w_misal) begin
              mem_wr_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
              misalign_q <= 1'b1;
`endif
            end else begin
              mem_a_q    <= addr_in;
              mem_dout_q <= wdata_in[7:0];
              mem_wr_q   <= w_is_store;
            end
          end else begin
            we_wb_q    <= we_in && !w_is_load && !w_is_store;
            waddr_wb_q <= rd_in;
            wdata_wb_q <= wdata_in;
          end
        end
        S_ISSUE: begin
          data_q <= w_packed;
          if (w_last_issue) begin
            mem_wr_q <= 1'b0;
          end else begin
            byte_q     <= w_next_byte;
            mem_a_q    <= addr_q + {30'd0, w_next_byte};
            mem_dout_q <= data_q[{w_next_byte, 3'b000} +: 8];
          end
        end
        S_DRAIN: begin
          data_q <= w_packed;
          if (w_last_drain) begin
            we_wb_q    <= we_q && (rd_q != 5'd0);
            waddr_wb_q <= rd_q;
            wdata_wb_q <= w_ext;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: begin
          we_wb_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign mem.mem_a    = mem_a_q;
  assign mem.mem_dout = mem_dout_q;
  assign mem.mem_wr   = mem_wr_q & rdy;
  assign we_wb        = we_wb_q;
  assign waddr_wb     = waddr_wb_q;
  assign wdata_wb     = wdata_wb_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign     = misalign_q;
`endif

endmodule
`default_nettype wire
